// File: rtl/br_result_queue.sv
// ---------------------------------------------------------------------------
// br_result_queue
//
// Circular queue that collects resolved-branch results from the two integer
// pipes and drains them to the branch-predictor update port, up to two per
// cycle.
//
// Pairing rule for the drain side: the second output lane is used only when
// neither head entry was mispredicted and the two entries carry different
// history values. Two updates to the same counter index in one cycle cannot
// both land, and a mispredict repair has to be applied alone, so a
// mispredicted entry always leaves the queue by itself on lane 0.
//
// Optional feature macro: BR_RESULT_QUEUE_BYPASS_EN
//   When defined, an empty, unstalled, unflushed queue forwards its inputs
//   straight to the outputs in the same cycle. Any input that the pairing
//   rule does not forward is enqueued instead. When undefined, there is no
//   combinational input-to-output path and every entry is visible on the
//   outputs one cycle after it is written.
// ---------------------------------------------------------------------------
module br_result_queue #(
    parameter int ENTRY_NUM  = 8,
    parameter int HIST_WIDTH = 10,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,

    input  logic [1:0]            in_valid_i,
    input  logic [ADDR_WIDTH-1:0] in_addr_i    [2],
    input  logic [HIST_WIDTH-1:0] in_hist_i    [2],
    input  logic [1:0]            in_ctr_i     [2],
    input  logic [1:0]            in_taken_i,
    input  logic [1:0]            in_mispred_i,
    input  logic [1:0]            in_is_cond_i,
    output logic                  in_ready_o,

    input  logic                  drain_stall_i,
    output logic [1:0]            out_valid_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o   [2],
    output logic [HIST_WIDTH-1:0] out_hist_o   [2],
    output logic [1:0]            out_ctr_o    [2],
    output logic [1:0]            out_taken_o,
    output logic [1:0]            out_mispred_o,
    output logic [1:0]            out_is_cond_o,
    output logic [15:0]           mispred_cnt_o
);

    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_WIDTH + HIST_WIDTH + 5;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [HIST_WIDTH-1:0] hist;
        logic [1:0]            ctr;
        logic                  taken;
        logic                  mispred;
        logic                  is_cond;
    } entry_t;

    // Two entries may drain together only if neither is a mispredict and
    // they update different counter indices.
    function automatic logic pair_ok(input entry_t a, input entry_t b);
        return (!a.mispred) && (!b.mispred) && (a.hist != b.hist);
    endfunction

    // Payload storage: not reset, only the pointers define what is live.
    entry_t                mem_q [ENTRY_NUM];

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [15:0]           mispred_cnt_q, mispred_cnt_d;

    entry_t                in_ent_s   [2];
    entry_t                cand_s     [2];
    entry_t                head_ent_s [2];
    entry_t                src_s      [2];
    entry_t                wr_data_s  [2];

    logic [PTR_W-1:0]      head_p1_s;
    logic [PTR_W-1:0]      tail_p1_s;
    logic [1:0]            n_in_s;
    logic [1:0]            avail_s;
    logic [1:0]            n_out_s;
    logic [1:0]            n_deq_s;
    logic [1:0]            skip_s;
    logic [1:0]            n_enq_s;
    logic [1:0]            out_v_s;
    logic [1:0]            wr_en_s;
    logic                  bypass_s;
    logic                  in_ready_s;
    logic                  enq_en_s;

    // Pack the input lanes and compact them so valid lanes sit at the front
    // in lane order (a lone lane 1 becomes the first candidate).
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_ent_s[i].addr    = in_addr_i[i];
            in_ent_s[i].hist    = in_hist_i[i];
            in_ent_s[i].ctr     = in_ctr_i[i];
            in_ent_s[i].taken   = in_taken_i[i];
            in_ent_s[i].mispred = in_mispred_i[i];
            in_ent_s[i].is_cond = in_is_cond_i[i];
        end
        if (in_valid_i[0]) begin
            cand_s[0] = in_ent_s[0];
        end else begin
            cand_s[0] = in_ent_s[1];
        end
        cand_s[1] = in_ent_s[1];
        n_in_s    = {1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]};
    end

    // Read the two oldest slots; the pointer arithmetic wraps naturally.
    always_comb begin
        head_p1_s     = head_q + PTR_W'(1);
        head_ent_s[0] = mem_q[head_q];
        head_ent_s[1] = mem_q[head_p1_s];
    end

    // Choose the drain source (queue head, or the inputs when bypassing an
    // empty queue) and decide how many lanes are presented this cycle.
    always_comb begin
        bypass_s = 1'b0;
        src_s[0] = head_ent_s[0];
        src_s[1] = head_ent_s[1];
        if (count_q >= CNT_W'(2)) begin
            avail_s = 2'd2;
        end else begin
            avail_s = count_q[1:0];
        end
`ifdef BR_RESULT_QUEUE_BYPASS_EN
        if ((count_q == {CNT_W{1'b0}}) && !flush_i && !drain_stall_i) begin
            bypass_s = 1'b1;
            src_s[0] = cand_s[0];
            src_s[1] = cand_s[1];
            avail_s  = n_in_s;
        end else begin
            bypass_s = 1'b0;
        end
`endif
        out_v_s[0] = (!drain_stall_i) && (avail_s != 2'd0);
        out_v_s[1] = out_v_s[0] && (avail_s == 2'd2) && pair_ok(src_s[0], src_s[1]);
        n_out_s    = {1'b0, out_v_s[0]} + {1'b0, out_v_s[1]};
    end

    // Enqueue control: readiness comes from the registered count only, so a
    // same-cycle drain never lends space. Bypassed inputs are skipped over.
    always_comb begin
        in_ready_s = (count_q <= CNT_W'(ENTRY_NUM - 2));
        enq_en_s   = in_ready_s && !flush_i;
        if (bypass_s) begin
            n_deq_s = 2'd0;
            skip_s  = n_out_s;
        end else begin
            n_deq_s = n_out_s;
            skip_s  = 2'd0;
        end
        if (enq_en_s) begin
            n_enq_s = n_in_s - skip_s;
        end else begin
            n_enq_s = 2'd0;
        end
        wr_en_s[0] = (n_enq_s != 2'd0);
        wr_en_s[1] = (n_enq_s == 2'd2);
        if (skip_s == 2'd0) begin
            wr_data_s[0] = cand_s[0];
        end else begin
            wr_data_s[0] = cand_s[1];
        end
        wr_data_s[1] = cand_s[1];
        tail_p1_s    = tail_q + PTR_W'(1);
    end

    // Next-state for pointers, occupancy and the saturating mispredict count.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        mispred_cnt_d = mispred_cnt_q;

        if (out_v_s[0] && src_s[0].mispred && (mispred_cnt_q != 16'hFFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 16'd1;
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end

        if (flush_i) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            head_d  = head_q + PTR_W'(n_deq_s);
            tail_d  = tail_q + PTR_W'(n_enq_s);
            count_d = count_q + CNT_W'(n_enq_s) - CNT_W'(n_deq_s);
        end
    end

    // Drive the update port; idle lanes are forced to zero.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            entry_t ent;
            if (out_v_s[i]) begin
                ent = src_s[i];
            end else begin
                ent = {ENT_W{1'b0}};
            end
            out_addr_o[i]    = ent.addr;
            out_hist_o[i]    = ent.hist;
            out_ctr_o[i]     = ent.ctr;
            out_taken_o[i]   = ent.taken;
            out_mispred_o[i] = ent.mispred;
            out_is_cond_o[i] = ent.is_cond;
        end
        out_valid_o   = out_v_s;
        in_ready_o    = in_ready_s;
        mispred_cnt_o = mispred_cnt_q;
    end

    // Control state register with synchronous reset taking priority.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q        <= {PTR_W{1'b0}};
            tail_q        <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            mispred_cnt_q <= 16'd0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Payload writes at the tail and the slot after it; suppressed in reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en_s[0]) begin
            mem_q[tail_q] <= wr_data_s[0];
        end
        if (!rst_i && wr_en_s[1]) begin
            mem_q[tail_p1_s] <= wr_data_s[1];
        end
    end

endmodule

// File: tb/tb_br_result_queue.sv
// ---------------------------------------------------------------------------
// Testbench for br_result_queue (default parameters). Directed table vectors,
// hand-written corner sequences and randomized traffic, all compared against
// a queue-based reference model of the result-queue rules.
// ---------------------------------------------------------------------------
module tb_br_result_queue;

    localparam int N = 8;
`ifdef BR_RESULT_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [9:0]  hist;
        logic [1:0]  ctr;
        logic        taken;
        logic        mis;
        logic        cond;
    } ent_t;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] a0;
        logic [9:0]  h0;
        logic        m0;
        logic [31:0] a1;
        logic [9:0]  h1;
        logic        m1;
        logic        st;
        logic [1:0]  e_ov;
        logic [31:0] e_a0;
        logic [31:0] e_a1;
        logic [1:0]  e_mis;
        logic        e_rdy;
        logic [15:0] e_mc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  in_valid = 2'b00;
    logic [31:0] in_addr [2];
    logic [9:0]  in_hist [2];
    logic [1:0]  in_ctr  [2];
    logic [1:0]  in_taken = 2'b00;
    logic [1:0]  in_mis = 2'b00;
    logic [1:0]  in_cond = 2'b00;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_addr [2];
    logic [9:0]  out_hist [2];
    logic [1:0]  out_ctr  [2];
    logic [1:0]  out_taken, out_mis, out_cond;
    logic [15:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    ent_t        mq[$];
    logic [15:0] mmc = 16'd0;
    bit          e_byp;
    logic [1:0]  e_ov;
    ent_t        e_ent [2];

    br_result_queue #(.ENTRY_NUM(N), .HIST_WIDTH(10), .ADDR_WIDTH(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_addr_i    (in_addr),
        .in_hist_i    (in_hist),
        .in_ctr_i     (in_ctr),
        .in_taken_i   (in_taken),
        .in_mispred_i (in_mis),
        .in_is_cond_i (in_cond),
        .in_ready_o   (in_ready),
        .drain_stall_i(stall),
        .out_valid_o  (out_valid),
        .out_addr_o   (out_addr),
        .out_hist_o   (out_hist),
        .out_ctr_o    (out_ctr),
        .out_taken_o  (out_taken),
        .out_mispred_o(out_mis),
        .out_is_cond_o(out_cond),
        .mispred_cnt_o(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] a, input int h, input bit m);
        ent_t e;
        e.addr  = a;
        e.hist  = h[9:0];
        e.ctr   = a[3:2];
        e.taken = a[4];
        e.mis   = m;
        e.cond  = ~a[5];
        return e;
    endfunction

    task automatic drive(input logic [1:0] v, input ent_t e0, input ent_t e1,
                         input logic st, input logic fl);
        ent_t e [2];
        e[0] = e0;
        e[1] = e1;
        in_valid = v;
        stall    = st;
        flush    = fl;
        for (int i = 0; i < 2; i++) begin
            in_addr[i]  = e[i].addr;
            in_hist[i]  = e[i].hist;
            in_ctr[i]   = e[i].ctr;
            in_taken[i] = e[i].taken;
            in_mis[i]   = e[i].mis;
            in_cond[i]  = e[i].cond;
        end
    endtask

    function automatic ent_t in_ent(input int i);
        return {in_addr[i], in_hist[i], in_ctr[i], in_taken[i], in_mis[i], in_cond[i]};
    endfunction

    function automatic ent_t out_ent(input int i);
        return {out_addr[i], out_hist[i], out_ctr[i], out_taken[i], out_mis[i], out_cond[i]};
    endfunction

    // Reference: what the update port must show this cycle.
    function automatic void model_out();
        ent_t c[$];
        e_byp = BYP && (mq.size() == 0) && !flush && !stall;
        if (e_byp) begin
            for (int i = 0; i < 2; i++) if (in_valid[i]) c.push_back(in_ent(i));
        end else begin
            for (int i = 0; i < 2 && i < mq.size(); i++) c.push_back(mq[i]);
        end
        e_ov = 2'b00;
        e_ent[0] = '0;
        e_ent[1] = '0;
        if (!stall && c.size() >= 1) begin
            e_ov[0]  = 1'b1;
            e_ent[0] = c[0];
            if (c.size() >= 2 && !c[0].mis && !c[1].mis && c[0].hist != c[1].hist) begin
                e_ov[1]  = 1'b1;
                e_ent[1] = c[1];
            end
        end
    endfunction

    // Reference: state change at the clock edge.
    function automatic void model_edge();
        ent_t ins[$];
        int   n;
        bit   rdy;
        if (rst) begin
            mq.delete();
            mmc = 16'd0;
        end else begin
            if (e_ov[0] && e_ent[0].mis && mmc != 16'hFFFF) mmc = mmc + 16'd1;
            if (flush) begin
                mq.delete();
            end else begin
                rdy = (mq.size() <= N - 2);
                for (int i = 0; i < 2; i++) if (in_valid[i]) ins.push_back(in_ent(i));
                n = int'(e_ov[0]) + int'(e_ov[1]);
                if (e_byp) begin
                    for (int i = n; i < ins.size(); i++) mq.push_back(ins[i]);
                end else begin
                    for (int i = 0; i < n; i++) void'(mq.pop_front());
                    if (rdy) foreach (ins[i]) mq.push_back(ins[i]);
                end
            end
        end
    endfunction

    task automatic check_model();
        chk("out_valid", {62'd0, out_valid}, {62'd0, e_ov});
        chk("in_ready", {63'd0, in_ready}, {63'd0, (mq.size() <= N - 2)});
        chk("mispred_cnt", {48'd0, mispred_cnt}, {48'd0, mmc});
        chk("lane0", {17'd0, out_ent(0)}, {17'd0, e_ent[0]});
        chk("lane1", {17'd0, out_ent(1)}, {17'd0, e_ent[1]});
    endtask

    // One clock: settle, compare against the model, take the edge, advance model.
    task automatic step(input bit do_chk);
        #1;
        model_out();
        if (do_chk) check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    vec_t   tbl[$];
    int     got[$];
    ent_t   z;

    initial begin
        z = '0;
        drive(2'b00, z, z, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;

        // Directed table: entries enqueued under stall, then drained.
        //         v      a0         h0      m0    a1         h1      m1    st    e_ov   e_a0       e_a1       e_mis  rdy   mc
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 1'b1, 16'd0});
        tbl.push_back('{2'b11, 32'h100,   10'h1,  1'b0, 32'h104,   10'h2,  1'b0, 1'b1, 2'b00, 32'h0,     32'h0,     2'b00, 1'b1, 16'd0});
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b11, 32'h100,   32'h104,   2'b00, 1'b1, 16'd0});
        tbl.push_back('{2'b11, 32'h200,   10'h3,  1'b1, 32'h204,   10'h4,  1'b0, 1'b1, 2'b00, 32'h0,     32'h0,     2'b00, 1'b1, 16'd0});
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b01, 32'h200,   32'h0,     2'b01, 1'b1, 16'd0});
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b01, 32'h204,   32'h0,     2'b00, 1'b1, 16'd1});
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 1'b1, 16'd1});
        tbl.push_back('{2'b11, 32'h300,   10'h5A, 1'b0, 32'h304,   10'h5A, 1'b0, 1'b1, 2'b00, 32'h0,     32'h0,     2'b00, 1'b1, 16'd1});
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b01, 32'h300,   32'h0,     2'b00, 1'b1, 16'd1});
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b01, 32'h304,   32'h0,     2'b00, 1'b1, 16'd1});
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 1'b1, 16'd1});
        tbl.push_back('{2'b10, 32'h0,     10'h0,  1'b0, 32'h400,   10'h7,  1'b0, 1'b1, 2'b00, 32'h0,     32'h0,     2'b00, 1'b1, 16'd1});
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b01, 32'h400,   32'h0,     2'b00, 1'b1, 16'd1});
        tbl.push_back('{2'b00, 32'h0,     10'h0,  1'b0, 32'h0,     10'h0,  1'b0, 1'b0, 2'b00, 32'h0,     32'h0,     2'b00, 1'b1, 16'd1});

        foreach (tbl[r]) begin
            drive(tbl[r].v, mk(tbl[r].a0, int'(tbl[r].h0), tbl[r].m0),
                  mk(tbl[r].a1, int'(tbl[r].h1), tbl[r].m1), tbl[r].st, 1'b0);
            #1;
            chk($sformatf("tbl%0d.ov", r),  {62'd0, out_valid},   {62'd0, tbl[r].e_ov});
            chk($sformatf("tbl%0d.a0", r),  {32'd0, out_addr[0]}, {32'd0, tbl[r].e_a0});
            chk($sformatf("tbl%0d.a1", r),  {32'd0, out_addr[1]}, {32'd0, tbl[r].e_a1});
            chk($sformatf("tbl%0d.mis", r), {62'd0, out_mis},     {62'd0, tbl[r].e_mis});
            chk($sformatf("tbl%0d.rdy", r), {63'd0, in_ready},    {63'd0, tbl[r].e_rdy});
            chk($sformatf("tbl%0d.mc", r),  {48'd0, mispred_cnt}, {48'd0, tbl[r].e_mc});
            step(1'b1);
        end

        // Fill to 7 under stall (pointers start at slot 7, so this wraps).
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, mk(32'h500 + 32'(8 * k), 20 + 2 * k, 1'b0),
                  mk(32'h504 + 32'(8 * k), 21 + 2 * k, 1'b0), 1'b1, 1'b0);
            step(1'b1);
        end
        drive(2'b01, mk(32'h518, 26, 1'b0), z, 1'b1, 1'b0);
        step(1'b1);
        drive(2'b11, mk(32'h600, 40, 1'b0), mk(32'h604, 41, 1'b0), 1'b1, 1'b0);
        #1;
        chk("full.in_ready", {63'd0, in_ready}, 64'd0);
        chk("full.stalled", {62'd0, out_valid}, 64'd0);
        step(1'b1);
        got.delete();
        for (int c = 0; c < 8; c++) begin
            drive(2'b00, z, z, 1'b0, 1'b0);
            #1;
            if (out_valid[0]) got.push_back(int'(out_addr[0]));
            if (out_valid[1]) got.push_back(int'(out_addr[1]));
            step(1'b1);
        end
        chk("drain.count", 64'(got.size()), 64'd7);
        for (int k = 0; k < 7; k++) begin
            if (k < got.size()) chk($sformatf("drain.order%0d", k), 64'(got[k]), 64'(32'h500 + 32'(4 * k)));
        end

        // Flush while 4 entries are queued and a two-lane enqueue arrives.
        drive(2'b11, mk(32'h900, 50, 1'b0), mk(32'h904, 51, 1'b0), 1'b1, 1'b0);
        step(1'b1);
        drive(2'b11, mk(32'h908, 52, 1'b0), mk(32'h90C, 53, 1'b0), 1'b1, 1'b0);
        step(1'b1);
        drive(2'b11, mk(32'hA00, 60, 1'b0), mk(32'hA04, 61, 1'b0), 1'b0, 1'b1);
        step(1'b1);
        for (int c = 0; c < 3; c++) begin
            drive(2'b00, z, z, 1'b0, 1'b0);
            #1;
            chk("flush.empty", {62'd0, out_valid}, 64'd0);
            chk("flush.ready", {63'd0, in_ready}, 64'd1);
            step(1'b1);
        end

        // Single lane into an empty queue: same-cycle with bypass, else next cycle.
        drive(2'b01, mk(32'hB00, 70, 1'b0), z, 1'b0, 1'b0);
        #1;
        chk("lat.cycle0", {62'd0, out_valid}, BYP ? 64'd1 : 64'd0);
        step(1'b1);
        drive(2'b00, z, z, 1'b0, 1'b0);
        #1;
        chk("lat.cycle1", {62'd0, out_valid}, BYP ? 64'd0 : 64'd1);
        step(1'b1);
        step(1'b1);

        // Randomized traffic against the model, with occasional flush and reset.
        for (int c = 0; c < 800; c++) begin
            drive(2'($urandom_range(0, 3)),
                  mk($urandom, $urandom_range(0, 3), ($urandom_range(0, 3) == 0)),
                  mk($urandom, $urandom_range(0, 3), ($urandom_range(0, 3) == 0)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
            rst = ($urandom_range(0, 63) == 0);
            step(1'b1);
        end
        rst = 1'b0;

        // Saturation of the mispredict counter: one mispredicted drain per cycle.
        drive(2'b00, z, z, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        for (int c = 0; c < 65545; c++) begin
            drive(2'b01, mk(32'(c), c, 1'b1), z, 1'b0, 1'b0);
            step(c > 65520);
        end
        drive(2'b00, z, z, 1'b0, 1'b0);
        step(1'b1);
        step(1'b1);
        chk("mc.saturated", {48'd0, mispred_cnt}, 64'h0000_0000_0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/br_result_queue.md
BR_RESULT_QUEUE -- requirements
Module: br_result_queue

Interface
REQ-001 Parameter ENTRY_NUM, default 8, SHALL set queue depth; it is a power of two, minimum 4.
REQ-002 Parameter HIST_WIDTH, default 10, SHALL set the local-history/counter-index width.
REQ-003 Parameter ADDR_WIDTH, default 32, SHALL set the branch PC width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 flush  in  1  SHALL discard all queued entries.
REQ-007 in_valid[2]  in  1 each  SHALL mark the resolved-branch lanes from the two integer pipes; lane 0 is older.
REQ-008 in_addr[2], in_hist[2], in_ctr[2]  in  ADDR_WIDTH / HIST_WIDTH / 2  SHALL carry branch PC, history snapshot, and counter snapshot.
REQ-009 in_taken[2], in_mispred[2], in_is_cond[2]  in  1 each  SHALL carry the executed direction, the mispredict flag, and the conditional-branch flag.
REQ-010 in_ready  out  1  SHALL indicate that both lanes can be accepted this cycle.
REQ-011 drain_stall  in  1  SHALL block dequeue when high.
REQ-012 out_valid[2], out_addr[2], out_hist[2], out_ctr[2], out_taken[2], out_mispred[2], out_is_cond[2]  out  as inputs  SHALL present the branch results to the predictor update port.
REQ-013 mispred_cnt  out  16  SHALL count drained mispredicted entries.

Function
REQ-014 Storage SHALL be a circular buffer with head/tail pointers of log2(ENTRY_NUM) bits that wrap modulo ENTRY_NUM, and a count of log2(ENTRY_NUM)+1 bits.
REQ-015 in_ready SHALL equal (count <= ENTRY_NUM-2), computed from registered count only; it SHALL NOT take credit for a same-cycle dequeue.
REQ-016 Enqueue SHALL be all-or-nothing: if in_ready=0, no valid lane is written.
REQ-017 Valid lanes SHALL be written at consecutive tail slots in lane order; with only lane 1 valid, lane 1 SHALL take the tail slot and the tail SHALL advance by the number of valid lanes.
REQ-018 out_valid[0] SHALL be 1 when count>=1 and drain_stall=0; outputs SHALL be driven combinationally from the head slots.
REQ-019 out_valid[1] SHALL be 1 only when out_valid[0]=1, count>=2, neither the head nor head+1 entry has mispred=1, and their hist values differ.
REQ-020 Consequently, a mispredicted entry SHALL always drain alone on lane 0.
REQ-021 The head SHALL advance by the number of asserted out_valid lanes; the predictor consumes them without handshake.
REQ-022 Enqueue latency SHALL be 1 cycle: an entry written at edge N is visible on the outputs after edge N.
REQ-023 flush SHALL zero head, tail, and count at the next edge and SHALL override a same-cycle enqueue and dequeue; outputs during the flush cycle follow REQ-018.
REQ-024 Simultaneous enqueue and dequeue SHALL update count by (enqueued − dequeued) with no loss.
REQ-025 mispred_cnt SHALL increment by 1 for each cycle in which out_valid[0] and out_mispred[0] are both 1, and SHALL saturate at 16'hFFFF.
REQ-026 Outputs of lanes with out_valid=0 SHALL be driven to 0.

Reset
REQ-027 On rst, the following SHALL be cleared: head=0, tail=0, count=0, mispred_cnt=0; hence out_valid=0 and in_ready=1 after the edge.
REQ-028 Reset SHALL take priority over flush, enqueue, and dequeue; entry payload RAM SHALL NOT be cleared.
REQ-029 A reset asserted mid-operation SHALL discard all queued entries at that edge.

Configuration
REQ-030 With BR_RESULT_QUEUE_BYPASS_EN defined: when count=0, no flush is present, and drain_stall=0, valid inputs SHALL be forwarded to the outputs in the same cycle under REQ-019 rules and SHALL NOT be enqueued. Any input not forwarded SHALL be enqueued.
REQ-031 Without BR_RESULT_QUEUE_BYPASS_EN, no combinational input-to-output path SHALL exist; latency SHALL be exactly as stated in REQ-022.

Verification
REQ-032 Reset, then both lanes valid with different hist values, no mispredict → both appear on out lanes 0/1 the next cycle; count returns to 0.
REQ-033 Head entry with mispred=1, next entry clean → cycle 1: only out_valid[0] (mispred=1) and mispred_cnt=1; cycle 2: second entry drains on lane 0.
REQ-034 Two entries with equal hist=10'h05A → drained on consecutive cycles, one per cycle.
REQ-035 drain_stall=1 with 7 entries, ENTRY_NUM=8 → in_ready=0, and a two-lane input is rejected; release stall → 7 entries drain in order across the tail wrap-around.
REQ-036 flush asserted while 4 entries are queued and a two-lane enqueue is in progress → count=0 next cycle, and no enqueued entry ever appears.
REQ-037 Bypass build, empty queue, lane 0 valid → same-cycle out_valid[0]=1 and count stays 0; non-bypass build → output appears 1 cycle later.
